// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter (8 data bits, 1 stop bit).
// Optional even parity bit between data and stop when UART_TX_ARB_PARITY_EN is defined.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CLK_DIV = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_o,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_ARB_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      data_q, data_d;
   logic            tx_q, tx_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   winner;
   logic [GW-1:0]   cand;
   logic            found;
   logic            baud_last;

   assign baud_last = (baud_q == BW'(CLK_DIV - 1));
   assign tx_o      = tx_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = grant_q;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(grant_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      data_d    = data_q;
      grant_d   = grant_q;
      tx_d      = 1'b1;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            // rst gates the strobe so no accept is advertised while reset is held
            if (en && found && !rst) begin
               req_ready[winner] = 1'b1;
               data_d            = req_data[{winner, 3'b000} +: 8];
               grant_d           = winner;
               state_d           = START;
               tx_d              = 1'b0;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (baud_last) begin
               baud_d  = '0;
               state_d = DATA;
               tx_d    = data_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            tx_d = data_q[bit_q];
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^data_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = data_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef UART_TX_ARB_PARITY_EN
         PARITY: begin
            tx_d = ^data_q;
            if (baud_last) begin
               baud_d  = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         STOP: begin
            tx_d = 1'b1;
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
         grant_q <= GW'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         grant_q <= grant_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (NUM_REQ=4, CLK_DIV=16).
// Follows UART_TX_ARB_PARITY_EN the same way as the design.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CLK_DIV = 16;
`ifdef UART_TX_ARB_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_o;
   logic                 busy;
   logic [1:0]           grant_id;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      int          winner;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t vecs[10];

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .tx_o(tx_o),
      .busy(busy),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [3:0] v, input logic [31:0] d);
      en        = e;
      req_valid = v;
      req_data  = d;
   endtask

   // Expected serial level for bit slot pos of a frame carrying byte b.
   function automatic logic expBit(input logic [7:0] b, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
`ifdef UART_TX_ARB_PARITY_EN
      if (pos == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic waitReady(output logic got);
      #1;
      got = (req_ready != '0);
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         #1;
         got = (req_ready != '0);
      end
   endtask

   // Handshake, then record tx_o every cycle while busy and compare to the model frame.
   task automatic runFrame(input int w, input logic [7:0] b, input int drop_at, input string tag);
      logic got;
      int   cnt;
      int   bad;
      int   first_bad;
      logic rec[400];
      waitReady(got);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << w));
      @(posedge clk);
      @(negedge clk);
      cnt = 0;
      while (busy && cnt < 400) begin
         rec[cnt] = tx_o;
         cnt++;
         if (cnt == drop_at) en = 1'b0;
         @(negedge clk);
      end
      checkOutput({tag, "_busy_len"}, 32'(cnt), 32'(FRAME_CYC));
      bad = 0;
      first_bad = -1;
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (c >= cnt || rec[c] !== expBit(b, c / CLK_DIV)) begin
            bad++;
            if (first_bad < 0) first_bad = c;
         end
      end
      if (bad != 0) $display("[TB] %s first bad cycle %0d", tag, first_bad);
      checkOutput({tag, "_frame_bad_cycles"}, 32'(bad), 32'd0);
      checkOutput({tag, "_idle_tx"}, 32'(tx_o), 32'd1);
      checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'(w));
   endtask

   task automatic checkQuiet(input int cycles, input string tag);
      int bad;
      bad = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (req_ready != '0 || tx_o !== 1'b1 || busy !== 1'b0) bad++;
      end
      checkOutput(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      logic got;

      vecs[0] = '{4'b1111, 32'hD3C2B1A0, 0, 8'hA0};
      vecs[1] = '{4'b1111, 32'h13243546, 1, 8'h35};
      vecs[2] = '{4'b1111, 32'hF00FAA01, 2, 8'h0F};
      vecs[3] = '{4'b1111, 32'h807EFF00, 3, 8'h80};
      vecs[4] = '{4'b1111, 32'h112233C3, 0, 8'hC3};
      vecs[5] = '{4'b0010, 32'h00005500, 1, 8'h55};
      vecs[6] = '{4'b0100, 32'h00070000, 2, 8'h07};
      vecs[7] = '{4'b1001, 32'h9A00005B, 3, 8'h9A};
      vecs[8] = '{4'b1001, 32'h9A00005B, 0, 8'h5B};
      vecs[9] = '{4'b1000, 32'hE1000000, 3, 8'hE1};

      rst = 1'b1;
      applyStimulus(1'b1, 4'b1111, 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", 32'(tx_o), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_grant", 32'(grant_id), 32'd3);
      applyStimulus(1'b0, 4'b0000, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, vecs[i].valid, vecs[i].data);
         runFrame(vecs[i].winner, vecs[i].exp_byte, -1, $sformatf("vec%0d", i));
      end

      applyStimulus(1'b0, 4'b1111, 32'h0000003C);
      checkQuiet(30, "en0_quiet");
      en = 1'b1;
      runFrame(0, 8'h3C, 20, "en_drop");
      checkQuiet(30, "en0_after_frame");

      applyStimulus(1'b1, 4'b0100, 32'h00990000);
      waitReady(got);
      checkOutput("rst_mid_ready", 32'(req_ready), 32'b0100);
      @(posedge clk);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_tx", 32'(tx_o), 32'd1);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_ready0", 32'(req_ready), 32'd0);
      checkOutput("rst_mid_grant", 32'(grant_id), 32'd3);
      repeat (3) @(negedge clk);
      applyStimulus(1'b1, 4'b0000, 32'h0);
      rst = 1'b0;
      checkQuiet(5, "rst_no_resume");
      applyStimulus(1'b1, 4'b1111, 32'h0000006D);
      runFrame(0, 8'h6D, -1, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter CLK_DIV, default 16, the clock cycles per UART bit (>=2).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, which enables new grants.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits, one byte-valid per requester.
REQ-007 SHALL have port req_data, input, NUM_REQ*8 bits; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have port req_ready, output, NUM_REQ bits, a one-hot byte-accept strobe.
REQ-009 SHALL have port tx_o, output, 1 bit, the serial line; idle level is 1.
REQ-010 SHALL have port busy, output, 1 bit, which is high while a frame is in progress.
REQ-011 SHALL have port grant_id, output, $clog2(NUM_REQ) bits, the index of the last accepted requester.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is present only per REQ-030.
REQ-013 In IDLE with en=1 and any req_valid bit set, SHALL select one winner round-robin, searching from (grant_id+1) mod NUM_REQ upward.
REQ-014 SHALL drive req_ready[winner]=1 combinationally in IDLE only; all other req_ready bits SHALL be 0, and req_ready SHALL be all-zero outside IDLE.
REQ-015 The handshake is req_valid[i] & req_ready[i]: at that edge, SHALL capture the byte, load grant_id=i, and move to START.
REQ-016 In START, SHALL hold tx_o=0 for CLK_DIV cycles.
REQ-017 In DATA, SHALL send 8 bits LSB first, each held CLK_DIV cycles, using a 3-bit bit counter and a baud counter that wraps at CLK_DIV-1.
REQ-018 In STOP, SHALL hold tx_o=1 for CLK_DIV cycles, then return to IDLE.
REQ-019 Frame length from START entry to IDLE re-entry SHALL be 10*CLK_DIV cycles (11*CLK_DIV with parity).
REQ-020 Back-to-back frames SHALL be separated by at least 1 IDLE cycle with tx_o=1.
REQ-021 busy SHALL be 1 exactly when state != IDLE.
REQ-022 tx_o SHALL be registered (glitch-free) and SHALL be 1 in IDLE.
REQ-023 Deasserting en mid-frame SHALL let the current frame complete; no new grant SHALL occur while en=0.
REQ-024 A requester dropping req_valid before its handshake SHALL have no effect on state or grant_id.
REQ-025 req_data SHALL be sampled only at the handshake edge; later changes SHALL NOT affect the frame in flight.

Reset
REQ-026 While rst=1, SHALL force state=IDLE, tx_o=1, busy=0, req_ready=0, and all counters to 0, asynchronously.
REQ-027 Reset SHALL set grant_id=NUM_REQ-1, so that requester 0 has first priority.
REQ-028 Reset mid-frame SHALL discard the byte; no partial frame SHALL resume after release.

Configuration
REQ-029 Macro UART_TX_ARB_PARITY_EN SHALL control parity generation.
REQ-030 With the macro defined, SHALL insert a PARITY state between DATA and STOP, held CLK_DIV cycles, with tx_o = XOR of the 8 data bits (even parity).
REQ-031 With the macro undefined, SHALL have no PARITY state and no parity logic; DATA SHALL go directly to STOP.

Verification (NUM_REQ=4, CLK_DIV=16)
REQ-032 Requester 1 sends 0x55 alone -> req_ready[1] high 1 cycle; tx_o = 0,1,0,1,0,1,0,1,0,1 at 16 cycles per bit; busy high 160 cycles; grant_id=1.
REQ-033 All four req_valid held high -> grant order 0,1,2,3,0; each frame is followed by at least 1 IDLE cycle.
REQ-034 After a grant to requester 2, requesters 0 and 3 raise req_valid together -> requester 3 wins, then requester 0.
REQ-035 rst pulsed at cycle 40 of a frame -> tx_o=1, busy=0, req_ready=0 immediately; the next grant goes to requester 0.
REQ-036 Byte 0x07 with the macro defined -> parity bit 1 and busy high 176 cycles; without the macro, busy high 160 cycles.
REQ-037 en=0 with req_valid=4'b1111 -> req_ready stays 0 and tx_o stays 1; en dropped at cycle 20 of a frame -> that frame completes.
